pwm_basic_gen: RTL and testbench



---
 rtl/pwm_basic_gen.sv | 65 ++++++
 tb/tb_pwm_basic_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pwm_basic_gen.sv
// Free-running PWM generator with R-bit duty resolution.
// One PWM period lasts 2^R clocks. The requested duty is captured into a
// shadow register only at the end of a period, so a duty change never
// shortens or stretches a pulse that is already in progress. Every output
// comes straight from a flop, so no input reaches an output combinationally.
module pwm_basic_gen #(
  parameter int R = 8  // duty/counter resolution in bits, legal 2..16
) (
  input  logic         clk,
  input  logic         reset,       // asynchronous, active-low
  input  logic [R-1:0] duty,
  output logic         pwm_out,
  output logic         period_tick
);

  localparam logic [R-1:0] CNT_MAX = {R{1'b1}};
  localparam logic [R-1:0] CNT_ONE = R'(1);

  logic [R-1:0] cnt;     // position inside the current period
  logic [R-1:0] duty_q;  // duty in force for the current period
  logic         wrap;    // last clock of the period

  assign wrap = (cnt == CNT_MAX);

  // Period counter: wraps from 2^R-1 back to 0, never stalls.
  // NOTE: state registers use non-blocking assignments so every flop sees
  // the pre-edge value of its neighbours; blocking here would chain them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Duty shadow: take the new request only on the wrap edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q <= '0;
    end else if (wrap) begin
      duty_q <= duty;
    end
  end

  // Period marker: high for the one clock following the wrap edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  // Waveform: compare pre-edge count with pre-edge shadow, one clock late.
  // Because cnt never reaches 2^R during a period, duty = 2^R-1 leaves
  // exactly one low clock and a full 100% output is impossible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_pwm_basic_gen.sv
// Self-checking bench for pwm_basic_gen: an R=8 and an R=4 instance share
// clock and reset. A period-level model predicts both outputs every clock,
// and directed checks pin the model to hand-computed edge numbers.
module tb_pwm_basic_gen;

  localparam int P8 = 256;
  localparam int P4 = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] duty8 = 8'h00;
  logic [3:0] duty4 = 4'h0;
  logic       pwm8, tick8, pwm4, tick4;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release and duty in force per period.
  int k8 = 0, k4 = 0;
  int eff8 = 0, eff4 = 0;
  logic exp_pwm8 = 1'b0, exp_tick8 = 1'b0, exp_pwm4 = 1'b0, exp_tick4 = 1'b0;

  // Directed bookkeeping: high clocks and ticks seen since last cleared.
  int hi8 = 0, hi4 = 0, tk8 = 0;

  pwm_basic_gen #(.R(8)) dut8 (
    .clk(clk), .reset(reset), .duty(duty8),
    .pwm_out(pwm8), .period_tick(tick8)
  );

  pwm_basic_gen #(.R(4)) dut4 (
    .clk(clk), .reset(reset), .duty(duty4),
    .pwm_out(pwm4), .period_tick(tick4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t k8=%0d)", name, actual, expected, $time, k8);
    end
  endtask

  // Model: edge k (1-based after release) sees count (k-1) mod P and the duty
  // captured at the most recent edge that was a multiple of P (0 before that).
  always @(posedge clk) begin
    if (!reset) begin
      k8 = 0; k4 = 0; eff8 = 0; eff4 = 0;
      exp_pwm8 = 1'b0; exp_tick8 = 1'b0; exp_pwm4 = 1'b0; exp_tick4 = 1'b0;
    end else begin
      k8++; k4++;
      exp_pwm8  = (((k8 - 1) % P8) < eff8);
      exp_tick8 = ((k8 % P8) == 0);
      if (exp_tick8) eff8 = int'(duty8);
      exp_pwm4  = (((k4 - 1) % P4) < eff4);
      exp_tick4 = ((k4 % P4) == 0);
      if (exp_tick4) eff4 = int'(duty4);
    end
    #1;
    check("model_pwm8",  int'(pwm8),  int'(exp_pwm8));
    check("model_tick8", int'(tick8), int'(exp_tick8));
    check("model_pwm4",  int'(pwm4),  int'(exp_pwm4));
    check("model_tick4", int'(tick4), int'(exp_tick4));
  end

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hi8 += int'(pwm8);
      hi4 += int'(pwm4);
      tk8 += int'(tick8);
    end
  endtask

  initial begin
    // Reset held with a non-zero request: everything stays low.
    reset = 1'b0; duty8 = 8'h7F; duty4 = 4'd5;
    step(10);
    check("rst_pwm8",  int'(pwm8),  0);
    check("rst_tick8", int'(tick8), 0);
    check("rst_pwm4",  int'(pwm4),  0);
    check("rst_tick4", int'(tick4), 0);

    // Release between edges; first 8-bit period must be all low.
    #2 reset = 1'b1;
    hi8 = 0; hi4 = 0;
    step(16);
    check("r4_tick_k16", int'(tick4), 1);
    hi4 = 0;
    step(16);
    check("r4_high_per_period", hi4, 5);
    check("r4_tick_k32", int'(tick4), 1);
    step(223);
    check("tick_k255", int'(tick8), 0);
    step(1);
    check("tick_k256", int'(tick8), 1);
    check("first_period_low", hi8, 0);
    hi8 = 0;
    step(1);
    check("pwm_k257", int'(pwm8), 1);
    check("tick_k257", int'(tick8), 0);
    step(126);
    check("pwm_k383", int'(pwm8), 1);
    step(1);
    check("pwm_k384", int'(pwm8), 0);
    step(128);
    check("tick_k512", int'(tick8), 1);
    check("high_0x7f_first", hi8, 127);
    hi8 = 0;
    step(256);
    check("high_0x7f_steady", hi8, 127);

    // duty 0: takes effect at the wrap after k=1024, then three dark periods.
    duty8 = 8'h00;
    step(256);
    hi8 = 0;
    step(768);
    check("duty0_never_high", hi8, 0);

    // duty 0xFF: in force from the wrap at k=2048.
    duty8 = 8'hFF;
    step(256);
    hi8 = 0;
    step(255);
    check("duty_ff_high", hi8, 255);
    step(1);
    check("duty_ff_tick", int'(tick8), 1);
    check("duty_ff_low_at_tick", int'(pwm8), 0);
    step(1);
    check("duty_ff_high_after_tick", int'(pwm8), 1);

    // Mid-period change: 0x40 captured at k=2560, 0xC0 requested at cnt=0x20.
    duty8 = 8'h40;
    step(255);
    hi8 = 0;
    step(32);
    duty8 = 8'hC0;
    step(224);
    check("change_keep_old", hi8, 64);
    check("change_tick", int'(tick8), 1);
    hi8 = 0; tk8 = 0;
    step(256);
    check("change_new_high", hi8, 192);
    check("tick_spacing_count", tk8, 1);
    check("tick_spacing_end", int'(tick8), 1);

    // Asynchronous reset in the middle of the high phase.
    step(10);
    check("pre_reset_high", int'(pwm8), 1);
    #2 reset = 1'b0;
    #1;
    check("async_pwm8",  int'(pwm8),  0);
    check("async_tick8", int'(tick8), 0);
    check("async_pwm4",  int'(pwm4),  0);
    step(3);
    #2 reset = 1'b1;
    hi8 = 0; tk8 = 0;
    step(255);
    check("restart_low", hi8, 0);
    check("restart_no_tick", tk8, 0);
    step(1);
    check("restart_tick", int'(tick8), 1);
    hi8 = 0;
    step(256);
    check("restart_high", hi8, 192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
